nco_wave_gen: RTL and testbench
===============================

// Module: nco_wave_gen
// PURPOSE
//  Numerically controlled oscillator core, directly downstream of the I2C configuration slave.
//  - Consumes the slave's enable/wave/frequency/duty_cycle outputs.
//  - Runs a 64-bit phase accumulator and produces square (PWM), sawtooth, triangle or sine samples.
//  - Parameter changes take effect only at a phase wrap, so no period is ever glitched.
// PARAMETERS
//  ACC_WIDTH  64  phase accumulator / frequency tuning word width
//  OUT_WIDTH  12  sample width, unsigned offset-binary
//  LUT_ADDR   8   quarter-wave sine table address bits (2^LUT_ADDR entries)
// PORTS
//  clk         in   1          system clock
//  reset       in   1          synchronous, active-low reset
//  enable      in   1          run request
//  wave        in   2          00 square, 01 sawtooth, 10 triangle, 11 sine
//  frequency   in   ACC_WIDTH  phase increment per clk
//  duty_cycle  in   16         square high fraction, duty_cycle/65536
//  wave_out    out  OUT_WIDTH  sample
//  sq_out      out  1          square/PWM bit (valid for every wave setting)
//  phase_wrap  out  1          1-clk pulse, aligned with the first sample of a new period
//  active      out  1          high in RUN or STOP
// BEHAVIOUR
//  Reset (reset==0 at posedge clk):
//  - phase=0, state=IDLE, shadows=0.
//  - wave_out=2^(OUT_WIDTH-1), sq_out=0, phase_wrap=0, active=0.
//  FSM states:
//  - IDLE: phase held at 0.
//    - enable=1: load shadows (freq_sh, duty_sh, wave_sh) from the inputs, go to RUN.
//  - RUN: phase <= phase+freq_sh (mod 2^ACC_WIDTH); wrap = carry out.
//    - On wrap: reload all shadows from the inputs.
//    - enable=0: go to STOP.
//  - STOP: keep accumulating until the next wrap, then go to IDLE with phase<=0.
//    - enable=1 during STOP: return to RUN, phase continuous.
//    - freq_sh==0: go to IDLE on the next clk.
//  - Shadows change only on an IDLE->RUN transition or a wrap.
//    Input changes mid-period are ignored until the period ends.
//  - freq_sh==0 in RUN: phase frozen, output constant, no wrap.
//  Waveform, with p=phase[ACC_WIDTH-1 -: 16] and N=OUT_WIDTH:
//  - square: sq=(p<duty_sh).
//    - duty 0 -> always 0; 0xFFFF -> high except 1/65536.
//    - wave_out = sq ? all-ones : 0.
//  - sawtooth: wave_out = phase[MSB -: N].
//  - triangle: t = phase[MSB-1 -: N]; wave_out = phase[MSB] ? ~t : t.
//  - sine: a = phase[MSB-2 -: LUT_ADDR]; if phase[MSB-1] then a=~a.
//    - m = LUT[a], unsigned magnitude 0..2^(N-1)-1.
//    - wave_out = phase[MSB] ? 2^(N-1)-1-m : 2^(N-1)+m.
//  Pipeline and timing:
//  - 2 register stages after the phase register: address/decode, then LUT read/output.
//  - The sample for the phase in cycle k appears in cycle k+2, identical for all waves.
//  - sq_out and phase_wrap are delayed to match.
//  - When IDLE is entered, outputs return to midscale/0 two clks later; active drops on entering IDLE.
//  Reset mid-operation: immediate return to reset values; the pipeline is flushed.
//  Simultaneous wrap and enable fall: the reload happens, then STOP; STOP runs one more full period.
// STRUCTURE
//  Package nco_pkg:
//  - WAVE_SQUARE/SAW/TRI/SINE 2-bit localparams (shared with the I2C slave).
//  - State encoding IDLE/RUN/STOP.
//  Sub-module nco_sine_lut:
//  - Registered synchronous ROM, LUT_ADDR in, OUT_WIDTH-1 out.
//  - Contents are round((2^(N-1)-1)*sin(pi/2*(i+0.5)/2^LUT_ADDR)).
// TESTING
//  1. Hold reset low 3 clks, with enable=1 -> outputs at reset values, active=0.
//  2. Sawtooth, freq=2^60 -> wrap every 16 clks.
//     wave_out steps 0,256,...,3840 starting 2 clks after RUN.
//  3. Square, freq=2^60, duty=0x8000 -> sq_out 8 high/8 low.
//     duty=0 -> always 0.
//  4. Change freq 2^60->2^59 mid-period -> current period still 16 clks, next periods 32 clks.
//  5. Drop enable at phase 5/16 -> 11 more steps, then IDLE and midscale.
//     Re-raise enable in STOP -> phase continuous.
//  6. Sine, freq=2^54 -> peak 4095±1 at quarter-period, 2048 at zero crossings, symmetric.
//     Reset mid-run -> midscale within 1 clk.

Source files
------------

// File: rtl/nco_pkg.sv
// nco_pkg: shared definitions for the NCO core.
//  - WAVE_* : waveform select codes, also used by the I2C configuration slave
//  - nco_state_e : control FSM states
//  - sine_q() : elaboration-time quarter-wave sine table entry (integer Taylor series)
package nco_pkg;

  localparam logic [1:0] WAVE_SQUARE = 2'b00;
  localparam logic [1:0] WAVE_SAW    = 2'b01;
  localparam logic [1:0] WAVE_TRI    = 2'b10;
  localparam logic [1:0] WAVE_SINE   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } nco_state_e;

  // round((2^(out_width-1)-1) * sin(pi/2 * (idx+0.5) / 2^lut_addr)).
  // Q30 fixed point keeps the table integer-only; the residual error
  // (~1e-9) is far below the rounding step.
  function automatic longint sine_q(input int idx, input int lut_addr, input int out_width);
    longint pi_q30;
    longint x;
    longint x2;
    longint term;
    longint sum;
    pi_q30 = 64'sd3373259426;
    x      = (pi_q30 * longint'(2 * idx + 1)) >>> (lut_addr + 2);
    x2     = (x * x) >>> 30;
    term   = x;
    sum    = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return (sum * ((longint'(1) <<< (out_width - 1)) - 1) + (longint'(1) <<< 29)) >>> 30;
  endfunction

endpackage

// File: rtl/nco_sine_lut.sv
// nco_sine_lut: registered quarter-wave sine ROM.
//  clk   in  clock
//  addr  in  LUT_ADDR quarter-wave index
//  data  out OUT_WIDTH-1 magnitude, one clk after addr
module nco_sine_lut
  import nco_pkg::*;
#(
  parameter int LUT_ADDR  = 8,
  parameter int OUT_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [LUT_ADDR-1:0]   addr,
  output logic [OUT_WIDTH-2:0]  data
);

  localparam int DEPTH = 1 << LUT_ADDR;

  logic [OUT_WIDTH-2:0] rom [DEPTH];
  logic [OUT_WIDTH-2:0] data_d, data_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam longint VAL = sine_q(i, LUT_ADDR, OUT_WIDTH);
    assign rom[i] = VAL[OUT_WIDTH-2:0];
  end

  always_comb data_d = rom[addr];

  // No reset: the consumer ignores this value while its valid bit is low.
  always_ff @(posedge clk) data_q <= data_d;

  assign data = data_q;

endmodule

// File: rtl/nco_wave_gen.sv
// nco_wave_gen: NCO core with 64-bit phase accumulator and square/saw/tri/sine output.
//  clk, reset      clock, synchronous active-low reset
//  enable          run request (stop completes the current period)
//  wave            waveform select (nco_pkg WAVE_*)
//  frequency       phase increment per clk
//  duty_cycle      square high fraction, duty_cycle/65536
//  wave_out        offset-binary sample, 2 clks after its phase
//  sq_out          PWM bit, aligned with wave_out
//  phase_wrap      1-clk pulse on the first sample of a new period
//  active          high in RUN or STOP
// Settings are shadowed and only reloaded at a phase wrap (or on start).
module nco_wave_gen
  import nco_pkg::*;
#(
  parameter int ACC_WIDTH = 64,
  parameter int OUT_WIDTH = 12,
  parameter int LUT_ADDR  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            wave,
  input  logic [ACC_WIDTH-1:0]  frequency,
  input  logic [15:0]           duty_cycle,
  output logic [OUT_WIDTH-1:0]  wave_out,
  output logic                  sq_out,
  output logic                  phase_wrap,
  output logic                  active
);

  localparam logic [OUT_WIDTH-1:0] MID = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam int MSB = ACC_WIDTH - 1;

  // Control / accumulator stage
  nco_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] phase_q, phase_d;
  logic [ACC_WIDTH-1:0] freq_sh_q, freq_sh_d;
  logic [15:0]          duty_sh_q, duty_sh_d;
  logic [1:0]           wave_sh_q, wave_sh_d;
  logic                 wrap_q, wrap_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;

  // Decode stage (aligned with LUT output)
  logic                 s1_vld_q, s1_vld_d;
  logic [1:0]           s1_wave_q, s1_wave_d;
  logic                 s1_sq_q, s1_sq_d;
  logic                 s1_wrap_q, s1_wrap_d;
  logic                 s1_neg_q, s1_neg_d;
  logic [OUT_WIDTH-1:0] s1_lin_q, s1_lin_d;
  logic [LUT_ADDR-1:0]  lut_addr;
  logic [OUT_WIDTH-2:0] lut_data;
  logic [OUT_WIDTH-1:0] tri_t;

  // Output stage
  logic [OUT_WIDTH-1:0] wave_out_q, wave_out_d;
  logic                 sq_out_q, sq_out_d;
  logic                 phase_wrap_q, phase_wrap_d;

  always_comb begin
    sum       = {1'b0, phase_q} + {1'b0, freq_sh_q};
    carry     = sum[ACC_WIDTH];
    state_d   = state_q;
    phase_d   = phase_q;
    freq_sh_d = freq_sh_q;
    duty_sh_d = duty_sh_q;
    wave_sh_d = wave_sh_q;
    wrap_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (enable) begin
          state_d   = ST_RUN;
          freq_sh_d = frequency;
          duty_sh_d = duty_cycle;
          wave_sh_d = wave;
        end
      end
      ST_RUN, ST_STOP: begin
        phase_d = sum[ACC_WIDTH-1:0];
        wrap_d  = carry;
        if (state_q == ST_RUN || enable) begin
          // A wrap reloads before any stop request takes effect, so STOP
          // then runs one full period with the fresh settings.
          state_d = enable ? ST_RUN : ST_STOP;
          if (carry) begin
            freq_sh_d = frequency;
            duty_sh_d = duty_cycle;
            wave_sh_d = wave;
          end
        end else if (carry || freq_sh_q == '0) begin
          state_d = ST_IDLE;
          phase_d = '0;
          wrap_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lut_addr = phase_q[MSB-2 -: LUT_ADDR];
    if (phase_q[MSB-1]) lut_addr = ~lut_addr;
    tri_t     = phase_q[MSB-1 -: OUT_WIDTH];
    s1_vld_d  = (state_q != ST_IDLE);
    s1_wave_d = wave_sh_q;
    s1_sq_d   = (phase_q[MSB -: 16] < duty_sh_q);
    s1_wrap_d = wrap_q;
    s1_neg_d  = phase_q[MSB];
    s1_lin_d  = (wave_sh_q == WAVE_TRI) ? (phase_q[MSB] ? ~tri_t : tri_t)
                                        : phase_q[MSB -: OUT_WIDTH];
  end

  nco_sine_lut #(.LUT_ADDR(LUT_ADDR), .OUT_WIDTH(OUT_WIDTH)) u_lut (
    .clk  (clk),
    .addr (lut_addr),
    .data (lut_data)
  );

  always_comb begin
    wave_out_d   = MID;
    sq_out_d     = 1'b0;
    phase_wrap_d = 1'b0;
    if (s1_vld_q) begin
      sq_out_d     = s1_sq_q;
      phase_wrap_d = s1_wrap_q;
      case (s1_wave_q)
        WAVE_SQUARE: wave_out_d = s1_sq_q ? '1 : '0;
        // {0,~m} = MID-1-m and {1,m} = MID+m for m < MID
        WAVE_SINE:   wave_out_d = s1_neg_q ? {1'b0, ~lut_data} : {1'b1, lut_data};
        default:     wave_out_d = s1_lin_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      freq_sh_q    <= '0;
      duty_sh_q    <= '0;
      wave_sh_q    <= '0;
      wrap_q       <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_wave_q    <= '0;
      s1_sq_q      <= 1'b0;
      s1_wrap_q    <= 1'b0;
      s1_neg_q     <= 1'b0;
      s1_lin_q     <= '0;
      wave_out_q   <= MID;
      sq_out_q     <= 1'b0;
      phase_wrap_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      freq_sh_q    <= freq_sh_d;
      duty_sh_q    <= duty_sh_d;
      wave_sh_q    <= wave_sh_d;
      wrap_q       <= wrap_d;
      s1_vld_q     <= s1_vld_d;
      s1_wave_q    <= s1_wave_d;
      s1_sq_q      <= s1_sq_d;
      s1_wrap_q    <= s1_wrap_d;
      s1_neg_q     <= s1_neg_d;
      s1_lin_q     <= s1_lin_d;
      wave_out_q   <= wave_out_d;
      sq_out_q     <= sq_out_d;
      phase_wrap_q <= phase_wrap_d;
    end
  end

  assign wave_out   = wave_out_q;
  assign sq_out     = sq_out_q;
  assign phase_wrap = phase_wrap_q;
  assign active     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nco_wave_gen.sv
// Testbench for nco_wave_gen: directed scenarios plus random stimulus, every
// cycle compared against a behavioural model (phase as an integer, samples
// from arithmetic on the phase, sine from $sin).
module tb_nco_wave_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  wave = 2'd0;
  logic [63:0] frequency = 64'd0;
  logic [15:0] duty_cycle = 16'd0;
  logic [11:0] wave_out;
  logic        sq_out;
  logic        phase_wrap;
  logic        active;

  int n_chk = 0;
  int n_fail = 0;

  nco_wave_gen dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .wave       (wave),
    .frequency  (frequency),
    .duty_cycle (duty_cycle),
    .wave_out   (wave_out),
    .sq_out     (sq_out),
    .phase_wrap (phase_wrap),
    .active     (active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] w;
    logic        sq;
    logic        wr;
  } smp_t;

  // model: 0 idle, 1 running, 2 stopping
  int          m_mode;
  logic [63:0] m_phase;
  logic [63:0] m_freq;
  logic [15:0] m_duty;
  logic [1:0]  m_wave;
  bit          m_wrap;
  smp_t        hist[$];
  smp_t        exp_s;
  int          lut[256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, expv);
    end
  endtask

  function automatic smp_t mk_sample();
    smp_t s;
    int   v;
    int   q;
    int   idx;
    s.sq = 1'b0;
    s.wr = 1'b0;
    v    = 2048;
    if (m_mode != 0) begin
      s.sq = (m_phase[63:48] < m_duty);
      s.wr = m_wrap;
      case (m_wave)
        2'd0: v = s.sq ? 4095 : 0;
        2'd1: v = int'(m_phase >> 52);
        2'd2: begin
          q = int'(m_phase >> 51);
          v = (q < 4096) ? q : 8191 - q;
        end
        default: begin
          q   = int'(m_phase >> 54);
          idx = q % 256;
          if ((q / 256) % 2 == 1) idx = 255 - idx;
          v = (q >= 512) ? 2047 - lut[idx] : 2048 + lut[idx];
        end
      endcase
    end
    s.w = 12'(v);
    return s;
  endfunction

  task automatic reload();
    m_freq = frequency;
    m_duty = duty_cycle;
    m_wave = wave;
  endtask

  // One clk edge of the reference behaviour, using the inputs the DUT sampled.
  task automatic model_edge();
    logic [64:0] nx;
    smp_t        mid;
    mid = '{w: 12'd2048, sq: 1'b0, wr: 1'b0};
    if (!reset) begin
      m_mode = 0; m_phase = '0; m_freq = '0; m_duty = '0; m_wave = '0; m_wrap = 0;
      hist.delete();
      hist.push_back(mid);
      hist.push_back(mid);
      exp_s = mid;
      return;
    end
    m_wrap = 0;
    if (m_mode == 0) begin
      m_phase = '0;
      if (enable) begin reload(); m_mode = 1; end
    end else begin
      nx      = {1'b0, m_phase} + {1'b0, m_freq};
      m_phase = nx[63:0];
      m_wrap  = nx[64];
      if (m_mode == 1 || enable) begin
        if (nx[64]) reload();
        m_mode = enable ? 1 : 2;
      end else if (nx[64] || m_freq == 0) begin
        m_mode = 0; m_phase = '0; m_wrap = 0;
      end
    end
    hist.push_back(mk_sample());
    exp_s = hist.pop_front();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("wave_out",   64'(wave_out),   64'(exp_s.w));
    chk("sq_out",     64'(sq_out),     64'(exp_s.sq));
    chk("phase_wrap", 64'(phase_wrap), 64'(exp_s.wr));
    chk("active",     64'(active),     64'(m_mode != 0));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      lut[i] = int'($floor(2047.0 * $sin(3.141592653589793 * (real'(i) + 0.5) / 512.0) + 0.5));

    // reset held with enable high
    enable = 1'b1;
    ticks(3);
    chk("reset_wave_mid", 64'(wave_out), 64'd2048);
    chk("reset_active",   64'(active),   64'd0);

    // sawtooth, wrap every 16
    reset = 1'b1; wave = 2'd1; frequency = 64'd1 << 60; duty_cycle = 16'h8000;
    ticks(40);

    // square 50% then 0%
    enable = 1'b0; ticks(20);
    wave = 2'd0; enable = 1'b1; ticks(40);
    duty_cycle = 16'h0000; ticks(40);
    duty_cycle = 16'hFFFF; ticks(20);

    // frequency change mid-period
    wave = 2'd1; duty_cycle = 16'h4000; ticks(5);
    frequency = 64'd1 << 59; ticks(80);

    // stop at phase 5/16, then stop again and re-raise during STOP
    enable = 1'b0; ticks(40);
    frequency = 64'd1 << 60; enable = 1'b1; ticks(6);
    enable = 1'b0; ticks(14);
    chk("stop_active", 64'(active), 64'd0);
    ticks(3);
    chk("stop_midscale", 64'(wave_out), 64'd2048);
    enable = 1'b1; ticks(8);
    enable = 1'b0; ticks(4);
    enable = 1'b1; ticks(20);

    // triangle
    wave = 2'd2; ticks(40);

    // sine, slow, then reset mid-run
    wave = 2'd3; frequency = 64'd1 << 54; ticks(1100);
    reset = 1'b0; ticks(1);
    chk("reset_mid_run", 64'(wave_out), 64'd2048);
    reset = 1'b1; ticks(4);

    // random
    for (int it = 0; it < 60; it++) begin
      wave       = 2'($urandom_range(0, 3));
      duty_cycle = 16'($urandom);
      frequency  = ({32'($urandom), 32'($urandom)} >> $urandom_range(1, 6));
      if ($urandom_range(0, 15) == 0) frequency = '0;
      enable     = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 19) != 0);
      ticks($urandom_range(1, 40));
      reset = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
